// File: rtl/sram_bank_arbiter.sv
// sram_bank_arbiter
//
// Shares NUM_SRAMS single-port SRAM banks between NUM_REQ requesters
// (0=gemm1, 1=gemm2, 2=elem, 3=axi). Each bank has its own round-robin
// arbiter with burst locking. Grants are combinational (req_ready).
// The bank command is registered one cycle after the grant. Read data is
// routed back to the issuing requester two cycles after the handshake.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous reset, active-low
//   req_valid   per-requester request present
//   req_ready   per-requester beat accepted this cycle (combinational)
//   req_we      per-requester write (1) / read (0)
//   req_last    per-requester final beat; 0 keeps the bank locked
//   req_idx     per-requester target bank (packed, IDX_WIDTH each)
//   req_addr    per-requester bank address (packed, ADDR_WIDTH each)
//   req_wdata   per-requester write data (packed, DATA_WIDTH each)
//   rsp_valid   per-requester read data valid
//   rsp_data    per-requester read data, held while rsp_valid is low
//   sram_en     per-bank enable (registered)
//   sram_we     per-bank write enable (registered)
//   sram_addr   per-bank address (registered)
//   sram_wdata  per-bank write data (registered)
//   sram_rdata  per-bank read data, valid one cycle after sram_en
module sram_bank_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int NUM_SRAMS  = 4,
    parameter int IDX_WIDTH  = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0]               req_we,
    input  logic [NUM_REQ-1:0]               req_last,
    input  logic [NUM_REQ*IDX_WIDTH-1:0]     req_idx,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [NUM_REQ*DATA_WIDTH-1:0]    rsp_data,
    output logic [NUM_SRAMS-1:0]             sram_en,
    output logic [NUM_SRAMS-1:0]             sram_we,
    output logic [NUM_SRAMS*ADDR_WIDTH-1:0]  sram_addr,
    output logic [NUM_SRAMS*DATA_WIDTH-1:0]  sram_wdata,
    input  logic [NUM_SRAMS*DATA_WIDTH-1:0]  sram_rdata
);

    localparam int REQ_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    // Unpacked views of the flattened buses
    logic [IDX_WIDTH-1:0]  idx_a   [NUM_REQ];
    logic [ADDR_WIDTH-1:0] addr_a  [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_a [NUM_REQ];
    logic [DATA_WIDTH-1:0] rdata_a [NUM_SRAMS];

    // Per-bank arbitration state
    state_t                state  [NUM_SRAMS];
    logic [REQ_W-1:0]      rr_ptr [NUM_SRAMS];
    logic [REQ_W-1:0]      owner  [NUM_SRAMS];

    // Combinational grant per bank
    logic [NUM_SRAMS-1:0]  gnt_any;
    logic [REQ_W-1:0]      gnt_id [NUM_SRAMS];
    logic [REQ_W:0]        cand;

    // Registered bank command
    logic [NUM_SRAMS-1:0]  en_q;
    logic [NUM_SRAMS-1:0]  we_q;
    logic [ADDR_WIDTH-1:0] addr_q  [NUM_SRAMS];
    logic [DATA_WIDTH-1:0] wdata_q [NUM_SRAMS];

    // Two-stage response tag pipe per bank. Writes never enter the pipe,
    // so the valid bit doubles as the read flag.
    logic [NUM_SRAMS-1:0]  tag1_valid;
    logic [NUM_SRAMS-1:0]  tag2_valid;
    logic [REQ_W-1:0]      tag1_id [NUM_SRAMS];
    logic [REQ_W-1:0]      tag2_id [NUM_SRAMS];

    // Response routing
    logic [NUM_REQ-1:0]    rsp_v;
    logic [DATA_WIDTH-1:0] rsp_d    [NUM_REQ];
    logic [DATA_WIDTH-1:0] rsp_hold [NUM_REQ];

    genvar g;
    generate
        for (g = 0; g < NUM_REQ; g++) begin : g_req
            assign idx_a[g]   = req_idx[g*IDX_WIDTH +: IDX_WIDTH];
            assign addr_a[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
            assign wdata_a[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
            assign rsp_data[g*DATA_WIDTH +: DATA_WIDTH] = rst ? rsp_d[g] : '0;
        end
        for (g = 0; g < NUM_SRAMS; g++) begin : g_bank
            assign rdata_a[g] = sram_rdata[g*DATA_WIDTH +: DATA_WIDTH];
            assign sram_addr[g*ADDR_WIDTH +: ADDR_WIDTH]  = addr_q[g];
            assign sram_wdata[g*DATA_WIDTH +: DATA_WIDTH] = wdata_q[g];
        end
    endgenerate

    assign sram_en   = en_q;
    assign sram_we   = we_q;
    assign rsp_valid = rst ? rsp_v : '0;

    // Per-bank winner selection. In IDLE the search starts at rr_ptr and
    // wraps; a locked bank only considers its owner. A bank index that
    // matches no bank simply never wins anywhere.
    always_comb begin
        gnt_any = '0;
        cand    = '0;
        for (int b = 0; b < NUM_SRAMS; b++) begin
            gnt_id[b] = '0;
            if (state[b] == LOCKED) begin
                if (req_valid[owner[b]] && (idx_a[owner[b]] == IDX_WIDTH'(b))) begin
                    gnt_any[b] = 1'b1;
                    gnt_id[b]  = owner[b];
                end
            end else begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    cand = {1'b0, rr_ptr[b]} + (REQ_W+1)'(i);
                    if (cand >= (REQ_W+1)'(NUM_REQ)) begin
                        cand = cand - (REQ_W+1)'(NUM_REQ);
                    end
                    if (!gnt_any[b] && req_valid[cand[REQ_W-1:0]] &&
                        (idx_a[cand[REQ_W-1:0]] == IDX_WIDTH'(b))) begin
                        gnt_any[b] = 1'b1;
                        gnt_id[b]  = cand[REQ_W-1:0];
                    end
                end
            end
            if (!rst) begin
                gnt_any[b] = 1'b0;
            end
        end
    end

    // Each requester targets one bank, so at most one bank grants it.
    always_comb begin
        req_ready = '0;
        for (int b = 0; b < NUM_SRAMS; b++) begin
            if (gnt_any[b]) begin
                req_ready[gnt_id[b]] = 1'b1;
            end
        end
    end

    // A bank's read data appears in the same cycle its tag reaches stage 2.
    always_comb begin
        rsp_v = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            rsp_d[r] = rsp_hold[r];
            for (int b = 0; b < NUM_SRAMS; b++) begin
                if (tag2_valid[b] && (tag2_id[b] == REQ_W'(r))) begin
                    rsp_v[r] = 1'b1;
                    rsp_d[r] = rdata_a[b];
                end
            end
        end
    end

    // Bank FSMs, round-robin pointers, registered commands and tag pipes
    always_ff @(posedge clk) begin
        if (!rst) begin
            en_q       <= '0;
            we_q       <= '0;
            tag1_valid <= '0;
            tag2_valid <= '0;
            for (int b = 0; b < NUM_SRAMS; b++) begin
                state[b]   <= IDLE;
                rr_ptr[b]  <= '0;
                owner[b]   <= '0;
                addr_q[b]  <= '0;
                wdata_q[b] <= '0;
                tag1_id[b] <= '0;
                tag2_id[b] <= '0;
            end
            for (int r = 0; r < NUM_REQ; r++) begin
                rsp_hold[r] <= '0;
            end
        end else begin
            for (int b = 0; b < NUM_SRAMS; b++) begin
                en_q[b]       <= gnt_any[b];
                we_q[b]       <= gnt_any[b] & req_we[gnt_id[b]];
                addr_q[b]     <= gnt_any[b] ? addr_a[gnt_id[b]]  : '0;
                wdata_q[b]    <= gnt_any[b] ? wdata_a[gnt_id[b]] : '0;
                tag1_valid[b] <= gnt_any[b] & ~req_we[gnt_id[b]];
                tag1_id[b]    <= gnt_id[b];
                tag2_valid[b] <= tag1_valid[b];
                tag2_id[b]    <= tag1_id[b];

                case (state[b])
                    IDLE: begin
                        if (gnt_any[b]) begin
                            rr_ptr[b] <= (gnt_id[b] == REQ_W'(NUM_REQ - 1)) ? '0
                                                                            : gnt_id[b] + 1'b1;
                            if (!req_last[gnt_id[b]]) begin
                                state[b] <= LOCKED;
                                owner[b] <= gnt_id[b];
                            end
                        end
                    end
                    LOCKED: begin
                        // An owner that pauses (valid low) keeps the bank.
                        if (gnt_any[b] && req_last[gnt_id[b]]) begin
                            state[b] <= IDLE;
                        end
                    end
                    default: state[b] <= IDLE;
                endcase
            end
            for (int r = 0; r < NUM_REQ; r++) begin
                if (rsp_v[r]) begin
                    rsp_hold[r] <= rsp_d[r];
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_bank_arbiter.sv
// tb_sram_bank_arbiter
//
// Directed bench for sram_bank_arbiter. A behavioural SRAM per bank is
// preloaded with data = bank*0x1000 + addr, so every expected read value
// is computed by hand. Accepted reads push their expected data and arrival
// cycle into a per-requester queue. A separate monitor pops and compares
// whenever rsp_valid is seen.
module tb_sram_bank_arbiter;

    localparam int NR = 4;
    localparam int NS = 4;
    localparam int IW = 2;
    localparam int AW = 16;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     req_we;
    logic [NR-1:0]     req_last;
    logic [NR*IW-1:0]  req_idx;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR-1:0]     rsp_valid;
    logic [NR*DW-1:0]  rsp_data;
    logic [NS-1:0]     sram_en;
    logic [NS-1:0]     sram_we;
    logic [NS*AW-1:0]  sram_addr;
    logic [NS*DW-1:0]  sram_wdata;
    logic [NS*DW-1:0]  sram_rdata;

    always #5 clk = ~clk;

    sram_bank_arbiter #(
        .NUM_REQ(NR), .NUM_SRAMS(NS), .IDX_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_last(req_last),
        .req_idx(req_idx), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    // Behavioural single-port banks with one cycle of read latency
    logic [DW-1:0] mem [NS][256];
    logic [DW-1:0] rdata_q [NS];

    initial begin
        for (int b = 0; b < NS; b++) begin
            rdata_q[b] = '0;
            for (int a = 0; a < 256; a++) begin
                mem[b][a] = 16'(b * 4096 + a);
            end
        end
    end

    always @(posedge clk) begin
        for (int b = 0; b < NS; b++) begin
            if (sram_en[b]) begin
                if (sram_we[b]) begin
                    mem[b][sram_addr[b*AW +: 8]] <= sram_wdata[b*DW +: DW];
                end else begin
                    rdata_q[b] <= mem[b][sram_addr[b*AW +: 8]];
                end
            end
        end
    end

    always_comb begin
        for (int b = 0; b < NS; b++) begin
            sram_rdata[b*DW +: DW] = rdata_q[b];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t          sbq [NR][$];
    logic [DW-1:0] exp_data [NR];
    bit            suppress_rsp = 1'b0;
    int            beat [NR];
    logic [NR-1:0] order [5];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic idleAll();
        req_valid = '0;
        req_we    = '0;
        req_last  = '1;
        req_idx   = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic applyStimulus(input int r, input logic we, input logic last,
                                 input logic [IW-1:0] idx, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata, input logic [DW-1:0] expd);
        req_valid[r]           = 1'b1;
        req_we[r]              = we;
        req_last[r]            = last;
        req_idx[r*IW +: IW]    = idx;
        req_addr[r*AW +: AW]   = addr;
        req_wdata[r*DW +: DW]  = wdata;
        exp_data[r]            = expd;
    endtask

    // Samples at the falling edge: checks the grant pattern and records
    // accepted reads for the monitor.
    task automatic sampleCycle(input logic [NR-1:0] exp_ready, input string name);
        logic [NR-1:0] hs;
        @(negedge clk);
        checkOutput(name, 64'(req_ready), 64'(exp_ready));
        hs = req_valid & req_ready;
        for (int r = 0; r < NR; r++) begin
            if (hs[r] && !req_we[r] && !suppress_rsp) begin
                sbq[r].push_back('{data: exp_data[r], cyc: cyc + 2});
            end
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            sampleCycle('0, "idle_ready");
            nextCycle();
        end
    endtask

    // Response monitor
    always @(negedge clk) begin : monitor
        exp_t e;
        for (int r = 0; r < NR; r++) begin
            if (rsp_valid[r] === 1'b1) begin
                if (sbq[r].size() == 0) begin
                    checkOutput($sformatf("rsp%0d_unexpected", r), 64'(rsp_valid[r]), 64'd0);
                end else begin
                    e = sbq[r].pop_front();
                    checkOutput($sformatf("rsp%0d_cycle", r), 64'(cyc), 64'(e.cyc));
                    checkOutput($sformatf("rsp%0d_data", r), 64'(rsp_data[r*DW +: DW]), 64'(e.data));
                end
            end else if (sbq[r].size() > 0 && sbq[r][0].cyc <= cyc) begin
                e = sbq[r].pop_front();
                checkOutput($sformatf("rsp%0d_missing", r), 64'(rsp_valid[r]), 64'd1);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset held with every requester asking for bank 0
        rst = 1'b0;
        idleAll();
        for (int r = 0; r < NR; r++) begin
            applyStimulus(r, 1'b0, 1'b1, 2'd0, 16'(16'h40 + r), 16'h0, 16'(16'h40 + r));
        end
        repeat (3) begin
            sampleCycle('0, "reset_ready");
            checkOutput("reset_sram_en", 64'(sram_en), 64'd0);
            checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
            nextCycle();
        end
        rst = 1'b1;
        sampleCycle(4'b0001, "first_grant");
        nextCycle();
        idleAll();
        idleCycles(3);

        // Four-way contention on bank 1
        order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
        order[3] = 4'b1000; order[4] = 4'b0001;
        for (int r = 0; r < NR; r++) beat[r] = 0;
        for (int k = 0; k < 5; k++) begin
            for (int r = 0; r < NR; r++) begin
                applyStimulus(r, 1'b0, 1'b1, 2'd1, 16'(16 * r + beat[r]), 16'h0,
                              16'(16'h1000 + 16 * r + beat[r]));
            end
            sampleCycle(order[k], $sformatf("contention_%0d", k));
            for (int r = 0; r < NR; r++) begin
                if (req_ready[r]) beat[r]++;
            end
            nextCycle();
        end
        idleAll();
        idleCycles(3);

        // Parallel banks, then read-after-write on bank 0
        applyStimulus(0, 1'b1, 1'b1, 2'd0, 16'd5, 16'h1234, 16'h0);
        applyStimulus(3, 1'b0, 1'b1, 2'd2, 16'd7, 16'h0, 16'h2007);
        sampleCycle(4'b1001, "parallel_grant");
        nextCycle();
        idleAll();
        applyStimulus(0, 1'b0, 1'b1, 2'd0, 16'd5, 16'h0, 16'h1234);
        sampleCycle(4'b0001, "raw_grant");
        checkOutput("par_sram_en", 64'(sram_en), 64'b0101);
        checkOutput("par_sram_we", 64'(sram_we), 64'b0001);
        checkOutput("par_addr0", 64'(sram_addr[0*AW +: AW]), 64'd5);
        checkOutput("par_wdata0", 64'(sram_wdata[0*DW +: DW]), 64'h1234);
        checkOutput("par_addr2", 64'(sram_addr[2*AW +: AW]), 64'd7);
        checkOutput("par_addr1_idle", 64'(sram_addr[1*AW +: AW]), 64'd0);
        nextCycle();
        idleAll();
        idleCycles(3);

        // Burst lock on bank 3 by req3, req0 waiting
        applyStimulus(3, 1'b0, 1'b0, 2'd3, 16'h80, 16'h0, 16'h3080);
        sampleCycle(4'b1000, "burst_b0");
        nextCycle();
        applyStimulus(3, 1'b0, 1'b0, 2'd3, 16'h81, 16'h0, 16'h3081);
        applyStimulus(0, 1'b0, 1'b1, 2'd3, 16'h90, 16'h0, 16'h3090);
        sampleCycle(4'b1000, "burst_b1");
        nextCycle();
        req_valid[3] = 1'b0;
        sampleCycle(4'b0000, "burst_gap0");
        nextCycle();
        sampleCycle(4'b0000, "burst_gap1");
        nextCycle();
        applyStimulus(3, 1'b0, 1'b0, 2'd3, 16'h82, 16'h0, 16'h3082);
        sampleCycle(4'b1000, "burst_b2");
        nextCycle();
        applyStimulus(3, 1'b0, 1'b1, 2'd3, 16'h83, 16'h0, 16'h3083);
        sampleCycle(4'b1000, "burst_last");
        nextCycle();
        req_valid[3] = 1'b0;
        sampleCycle(4'b0001, "burst_release");
        nextCycle();
        idleAll();
        idleCycles(3);

        // Back-to-back reads from req2 on bank 0
        for (int k = 0; k < 8; k++) begin
            applyStimulus(2, 1'b0, 1'b1, 2'd0, 16'(16'h60 + k), 16'h0, 16'(16'h0060 + k));
            sampleCycle(4'b0100, $sformatf("b2b_%0d", k));
            nextCycle();
        end
        idleAll();
        idleCycles(3);

        // Reset while a read is in flight and bank 3 is locked
        applyStimulus(1, 1'b0, 1'b1, 2'd2, 16'h11, 16'h0, 16'h0);
        applyStimulus(3, 1'b1, 1'b0, 2'd3, 16'h01, 16'hdead, 16'h0);
        suppress_rsp = 1'b1;
        sampleCycle(4'b1010, "midrst_grant");
        suppress_rsp = 1'b0;
        nextCycle();
        rst = 1'b0;
        idleAll();
        sampleCycle(4'b0000, "midrst_hold");
        nextCycle();
        rst = 1'b1;
        applyStimulus(0, 1'b0, 1'b1, 2'd3, 16'h02, 16'h0, 16'h3002);
        applyStimulus(1, 1'b0, 1'b1, 2'd2, 16'h12, 16'h0, 16'h2012);
        applyStimulus(2, 1'b0, 1'b1, 2'd2, 16'h13, 16'h0, 16'h2013);
        sampleCycle(4'b0011, "midrst_after");
        nextCycle();
        idleAll();
        applyStimulus(2, 1'b0, 1'b1, 2'd2, 16'h13, 16'h0, 16'h2013);
        sampleCycle(4'b0100, "midrst_req2");
        nextCycle();
        idleAll();
        idleCycles(4);

        for (int r = 0; r < NR; r++) begin
            checkOutput($sformatf("sb_drain%0d", r), 64'(sbq[r].size()), 64'd0);
        end

        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
